// File: rtl/message_receiver_pkg.sv
// message_receiver_pkg: shared state encoding and default widths for the message path
package message_receiver_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, HOLD = 2'd3} state_e;
  localparam int MSG_W_DEF = 16;
  localparam int ADDR_W_DEF = 2;
  function automatic int cnt_width(input int msg_w, input int addr_w);
    int m;
    m = msg_w > addr_w ? msg_w : addr_w;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/message_receiver_bit_counter.sv
// message_receiver_bit_counter: clearable up-counter flagging a programmable terminal value
module message_receiver_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign tc_o = cnt_q == term_i;
endmodule

// File: rtl/message_receiver.sv
// message_receiver: deserialises start/address/payload frames and presents matching payloads
// through a valid/ready handshake, pulsing drop for frames addressed elsewhere.
module message_receiver
  import message_receiver_pkg::*;
#(
  parameter int                MSG_W   = MSG_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MY_ADDR = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en_i,
  input  logic             sin_i,
  input  logic             msg_ready_i,
  output logic [MSG_W-1:0] msg_data_o,
  output logic             msg_valid_o,
  output logic             busy_o,
  output logic             drop_o
);
  localparam int CW = cnt_width(MSG_W, ADDR_W);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [MSG_W-1:0]    data_q;
  logic                drop_q, drop_d;
  logic                cnt_clr, cnt_en, tc;
  logic [CW-1:0]       term;
  assign term = state_q == ADDR ? CW'(ADDR_W - 1) : CW'(MSG_W - 1);
  message_receiver_bit_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (term),
    .tc_o   (tc)
  );
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: if (bit_en_i && !sin_i) begin
        state_d = ADDR;
        cnt_clr = 1'b1;
      end
      ADDR: if (bit_en_i) begin
        cnt_en = 1'b1;
        if (tc) begin
          state_d = DATA;
          cnt_clr = 1'b1;
        end
      end
      DATA: if (bit_en_i) begin
        cnt_en = 1'b1;
        if (tc) begin
          cnt_clr = 1'b1;
          state_d = addr_q == MY_ADDR ? HOLD : IDLE;
          drop_d  = addr_q != MY_ADDR;
        end
      end
      HOLD: if (msg_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Shift registers move only on accepted strobes, so HOLD keeps the payload frozen.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (state_q == ADDR && bit_en_i) addr_q <= ADDR_W'({addr_q, sin_i});
      if (state_q == DATA && bit_en_i) data_q <= MSG_W'({data_q, sin_i});
    end
  assign msg_data_o  = data_q;
  assign msg_valid_o = state_q == HOLD;
  assign busy_o      = state_q != IDLE;
  assign drop_o      = drop_q;
endmodule

// File: tb/tb_message_receiver.sv
// tb_message_receiver: scoreboard bench driving serial frames and checking handshaked payloads
module tb_message_receiver;
  logic        clk = 1'b0;
  logic        rst, bit_en, sin, msg_ready;
  logic [15:0] msg_data;
  logic        msg_valid, busy, drop;
  int          n_chk = 0, n_pass = 0, drop_pending = 0;
  logic [15:0] exp_q[$];
  logic        prev_valid = 1'b0, prev_drop = 1'b0;
  logic [15:0] prev_data = '0;

  message_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .bit_en_i    (bit_en),
    .sin_i       (sin),
    .msg_ready_i (msg_ready),
    .msg_data_o  (msg_data),
    .msg_valid_o (msg_valid),
    .busy_o      (busy),
    .drop_o      (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (msg_valid && prev_valid) check("stable", msg_data, prev_data);
      if (msg_valid && exp_q.size() == 0) check("spurious_valid", msg_valid, 0);
      else if (msg_valid && msg_ready) check("data", msg_data, exp_q.pop_front());
      if (drop) begin
        check("drop_width", prev_drop, 0);
        check("drop_expected", drop_pending > 0, 1);
        if (drop_pending > 0) drop_pending--;
      end
    end
    prev_valid = msg_valid;
    prev_data  = msg_data;
    prev_drop  = drop;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bit_en = 1'b1;
      sin    = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b, input int per);
    for (int i = 1; i < per; i++) begin
      tick();
      bit_en = 1'b0;
      sin    = 1'($urandom_range(0, 1));
    end
    tick();
    bit_en = 1'b1;
    sin    = b;
  endtask

  task automatic send_frame(input logic [1:0] addr, input logic [15:0] data, input int per, input int nbits);
    int t = 0;
    while (busy && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("busy_timeout", busy, 0);
    if (nbits == 16) begin
      if (addr == 2'b01) exp_q.push_back(data);
      else drop_pending++;
    end
    send_bit(1'b0, per);
    for (int i = 1; i >= 0; i--) send_bit(addr[i], per);
    for (int i = 15; i > 15 - nbits; i--) send_bit(data[i], per);
    tick();
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bit_en = 1'b0; sin = 1'b1; msg_ready = 1'b0;
    tick(); tick();
    check("rst_valid", msg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    check("rst_data", msg_data, 0);
    rst = 1'b0;
    idle(2);
    // matching frame held while consumer stalls
    send_frame(2'b01, 16'hA5C3, 1, 16);
    check("t1_valid", msg_valid, 1);
    check("t1_data", msg_data, 16'hA5C3);
    check("t1_busy", busy, 1);
    idle(3);
    check("t1_hold_valid", msg_valid, 1);
    check("t1_hold_data", msg_data, 16'hA5C3);
    msg_ready = 1'b1;
    tick();
    check("t1_release_valid", msg_valid, 0);
    check("t1_release_busy", busy, 0);
    check("t1_keep_data", msg_data, 16'hA5C3);
    msg_ready = 1'b0;
    // foreign address
    send_frame(2'b10, 16'hFFFF, 1, 16);
    check("t2_drop", drop, 1);
    check("t2_valid", msg_valid, 0);
    check("t2_busy", busy, 0);
    tick();
    check("t2_drop_end", drop, 0);
    check("t2_busy_after", busy, 0);
    // sparse strobes with noise between them
    send_frame(2'b01, 16'hA5C3, 4, 16);
    check("t3_valid", msg_valid, 1);
    check("t3_data", msg_data, 16'hA5C3);
    msg_ready = 1'b1;
    tick();
    check("t3_release", msg_valid, 0);
    // ready already high, then back-to-back frame
    send_frame(2'b01, 16'h0001, 1, 16);
    check("t4a_valid", msg_valid, 1);
    check("t4a_data", msg_data, 16'h0001);
    tick();
    check("t4a_one_cycle", msg_valid, 0);
    send_frame(2'b01, 16'h8000, 1, 16);
    check("t4b_valid", msg_valid, 1);
    check("t4b_data", msg_data, 16'h8000);
    tick();
    check("t4b_one_cycle", msg_valid, 0);
    msg_ready = 1'b0;
    // reset mid-payload
    send_frame(2'b01, 16'h1234, 1, 7);
    check("t5_mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", msg_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_drop", drop, 0);
    check("t5_rst_data", msg_data, 0);
    tick();
    rst = 1'b0;
    msg_ready = 1'b1;
    send_frame(2'b01, 16'h1234, 1, 16);
    check("t5_valid", msg_valid, 1);
    check("t5_data", msg_data, 16'h1234);
    tick();
    msg_ready = 1'b0;
    // start bit during HOLD is ignored
    send_frame(2'b01, 16'h5A5A, 1, 16);
    check("t6_valid", msg_valid, 1);
    bit_en = 1'b1;
    sin    = 1'b0;
    tick(); tick();
    sin = 1'b1;
    check("t6_hold_valid", msg_valid, 1);
    check("t6_hold_data", msg_data, 16'h5A5A);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    idle(4);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_valid", msg_valid, 0);
    idle(3);
    check("queue_empty", exp_q.size(), 0);
    check("drops_pending", drop_pending, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
